// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity mode, baud divisor and parity helper.
// Used by both the transmitter and the receiver so frame formats stay in lock-step.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop   = 3'd4
   } uart_state_e;

   typedef enum logic [1:0] {
      ParNone = 2'd0,
      ParEven = 2'd1,
      ParOdd  = 2'd2
   } parity_mode_e;

   localparam int unsigned MaxDataBits = 9;

   function automatic int unsigned calc_baud_div(input int unsigned clk_freq,
                                                 input int unsigned baud);
      return clk_freq / baud;
   endfunction

   // Callers zero-extend narrower words; the extra zeros leave the XOR reduction unchanged.
   function automatic logic parity_bit(input logic [MaxDataBits-1:0] data,
                                       input parity_mode_e mode);
      case (mode)
         ParEven: return ^data;
         ParOdd:  return ~^data;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with full/empty flags; simultaneous push and pop are both honoured.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_tx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_q, rd_q;
   logic             do_push, do_pop;

   assign empty    = (wr_q == rd_q);
   assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
      end
   end

   // Storage is not reset; a reset only discards entries by clearing the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/uart_tx_axis.sv
// UART transmitter with an AXI-Stream byte input: start, LSB-first data, optional parity, stop.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO in front of the serialiser.
module uart_tx_axis
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned DATA_BITS  = 8,
   parameter string       PARITY     = "even",
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done
);

   localparam int unsigned  BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
   localparam int unsigned  CNT_W    = $clog2(BAUD_DIV) + 1;
   localparam int unsigned  BIT_W    = $clog2(DATA_BITS) + 1;
   localparam parity_mode_e PAR_MODE = (PARITY == "none") ? ParNone :
                                       (PARITY == "odd")  ? ParOdd  : ParEven;

   if (BAUD_DIV < 2) begin : g_bad_baud
      $error("uart_tx_axis: CLK_FREQ/BAUD must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > MaxDataBits) begin : g_bad_bits
      $error("uart_tx_axis: DATA_BITS must be 5..9");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_axis: FIFO_DEPTH must be a power of 2");
   end

   uart_state_e              state_q, state_d;
   logic [CNT_W-1:0]         baud_q, baud_d;
   logic [BIT_W-1:0]         bit_q, bit_d;
   logic [DATA_BITS-1:0]     shift_q, shift_d;
   logic                     par_q, par_d;
   logic                     tx_q, tx_d;
   logic                     rst_q;
   logic                     start;
   logic [DATA_BITS-1:0]     start_data;
   logic [MaxDataBits-1:0]   par_data;
   logic                     baud_tick;

`ifdef UART_TX_FIFO_EN
   logic                 fifo_full, fifo_empty;
   logic [DATA_BITS-1:0] fifo_data;

   assign s_axis_tready = !fifo_full && !rst_q;
   assign start         = (state_q == StIdle) && !fifo_empty;
   assign start_data    = fifo_data;
   assign busy          = (state_q != StIdle) || !fifo_empty;

   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (s_axis_tvalid && s_axis_tready),
      .push_data (s_axis_tdata),
      .pop       (start),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );
`else
   assign s_axis_tready = (state_q == StIdle) && !rst_q;
   assign start         = s_axis_tvalid && s_axis_tready;
   assign start_data    = s_axis_tdata;
   assign busy          = (state_q != StIdle);
`endif

   assign tx        = tx_q;
   assign baud_tick = (baud_q == CNT_W'(BAUD_DIV - 1));

   always_comb begin
      par_data                = '0;
      par_data[DATA_BITS-1:0] = start_data;
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_done = 1'b0;

      // Every bit slot is BAUD_DIV cycles; state changes always coincide with the wrap.
      if (state_q != StIdle) begin
         baud_d = baud_tick ? '0 : baud_q + 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StStart;
               shift_d = start_data;
               par_d   = parity_bit(par_data, PAR_MODE);
               baud_d  = '0;
               bit_d   = '0;
            end
         end
         StStart: begin
            if (baud_tick) state_d = StData;
         end
         StData: begin
            if (baud_tick) begin
               shift_d = shift_q >> 1;
               if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = (PAR_MODE == ParNone) ? StStop : StParity;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         StParity: begin
            if (baud_tick) state_d = StStop;
         end
         StStop: begin
            if (baud_tick) begin
               if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                  state_d = StIdle;
                  bit_d   = '0;
                  tx_done = 1'b1;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Line level is decoded from the next state so tx itself can be a plain register.
      case (state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shift_d[0];
         StParity: tx_d = par_d;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         rst_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         rst_q   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx_axis.sv
// Scoreboard bench for uart_tx_axis: four instances (even, odd, none, even+2 stop) share a clock;
// stimulus queues expected frames, per-instance monitors decode tx and compare.
`timescale 1ns/1ps
module tb_uart_tx_axis;

   localparam int NI = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [NI-1:0] rst_v    = '1;
   logic [NI-1:0] tvalid_v = '0;
   logic [NI-1:0] rdy_v, tx_v, busy_v, done_v;
   logic [7:0]    tdata_a [NI];

   typedef struct {
      logic [7:0] data;
      logic       par;
      int         gap;
   } exp_t;

   exp_t q0[$], q1[$], q2[$], q3[$];
   int   total = 0;
   int   bad   = 0;
   bit   mon_en   [NI] = '{1'b1, 1'b1, 1'b1, 1'b1};
   int   in_frame [NI] = '{0, 0, 0, 0};

   uart_tx_axis #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY("even"),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
      .clk(clk), .rst(rst_v[0]), .s_axis_tdata(tdata_a[0]), .s_axis_tvalid(tvalid_v[0]),
      .s_axis_tready(rdy_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]));
   uart_tx_axis #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY("odd"),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
      .clk(clk), .rst(rst_v[1]), .s_axis_tdata(tdata_a[1]), .s_axis_tvalid(tvalid_v[1]),
      .s_axis_tready(rdy_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]));
   uart_tx_axis #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY("none"),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
      .clk(clk), .rst(rst_v[2]), .s_axis_tdata(tdata_a[2]), .s_axis_tvalid(tvalid_v[2]),
      .s_axis_tready(rdy_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]));
   uart_tx_axis #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY("even"),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
      .clk(clk), .rst(rst_v[3]), .s_axis_tdata(tdata_a[3]), .s_axis_tvalid(tvalid_v[3]),
      .s_axis_tready(rdy_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .tx_done(done_v[3]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic int qsize(input int i);
      case (i)
         0:       return q0.size();
         1:       return q1.size();
         2:       return q2.size();
         default: return q3.size();
      endcase
   endfunction

   task automatic qpush(input int i, input exp_t e);
      case (i)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         2:       q2.push_back(e);
         default: q3.push_back(e);
      endcase
   endtask

   task automatic qpop(input int i, output exp_t e);
      case (i)
         0:       e = q0.pop_front();
         1:       e = q1.pop_front();
         2:       e = q2.pop_front();
         default: e = q3.pop_front();
      endcase
   endtask

   function automatic logic exp_bit(input int s, input logic [7:0] d, input logic p,
                                    input bit haspar);
      if (s == 0) return 1'b0;
      if (s <= 8) return d[s-1];
      if (s == 9 && haspar) return p;
      return 1'b1;
   endfunction

   // Decodes one frame starting at the current negedge (first start-bit cycle).
   task automatic run_frame(input int i, inout int last_start);
      exp_t       e;
      bit         haspar;
      int         nstop, n, s, nbad, ndone, done_at;
      logic [7:0] d;
      logic       p;
      logic       exp_busy;
      haspar = (i != 2);
      nstop  = (i == 3) ? 2 : 1;
      n      = (1 + 8 + (haspar ? 1 : 0) + nstop) * 10;
      if (qsize(i) == 0) begin
         chk($sformatf("u%0d unexpected frame", i), 32'd1, 32'd0);
         e = '{data: 8'h00, par: 1'b0, gap: 0};
      end else begin
         qpop(i, e);
      end
      if (e.gap != 0) chk($sformatf("u%0d start gap", i), cyc - last_start, e.gap);
      last_start = cyc;
      nbad = 0; ndone = 0; done_at = 0; d = '0; p = 1'b0;
      for (int k = 1; k <= n; k++) begin
         if (k > 1) @(negedge clk);
         s = (k - 1) / 10;
         if (tx_v[i] !== exp_bit(s, e.data, e.par, haspar)) nbad++;
         if ((k - 1) % 10 == 4) begin
            if (s >= 1 && s <= 8) d[s-1] = tx_v[i];
            if (s == 9 && haspar) p = tx_v[i];
         end
         if (done_v[i] === 1'b1) begin
            ndone++;
            done_at = k;
         end
         if (k == n) begin
            chk($sformatf("u%0d busy last cycle", i), busy_v[i], 1);
`ifndef UART_TX_FIFO_EN
            chk($sformatf("u%0d tready last cycle", i), rdy_v[i], 0);
`endif
         end
      end
      chk($sformatf("u%0d data", i), d, e.data);
      if (haspar) chk($sformatf("u%0d parity", i), p, e.par);
      chk($sformatf("u%0d bit timing errors", i), nbad, 0);
      chk($sformatf("u%0d tx_done count", i), ndone, 1);
      chk($sformatf("u%0d tx_done cycle", i), done_at, n);
      @(negedge clk);
      chk($sformatf("u%0d idle tx", i), tx_v[i], 1);
`ifdef UART_TX_FIFO_EN
      exp_busy = (qsize(i) != 0);
`else
      chk($sformatf("u%0d tready after frame", i), rdy_v[i], 1);
      exp_busy = 1'b0;
`endif
      chk($sformatf("u%0d busy after frame", i), busy_v[i], exp_busy);
   endtask

   task automatic monitor(input int i);
      int last_start = -1;
      forever begin
         @(negedge clk);
         if (mon_en[i] && tx_v[i] === 1'b0) begin
            in_frame[i] = 1;
            run_frame(i, last_start);
            in_frame[i] = 0;
         end
      end
   endtask

   initial monitor(0);
   initial monitor(1);
   initial monitor(2);
   initial monitor(3);

   task automatic send(input int i, input logic [7:0] d, input logic p, input int gap,
                       input bit expect_frame);
      int w = 0;
      if (expect_frame) qpush(i, '{data: d, par: p, gap: gap});
      tdata_a[i]  = d;
      tvalid_v[i] = 1'b1;
      while (rdy_v[i] !== 1'b1 && w < 500) begin
         @(negedge clk);
         w++;
      end
      chk($sformatf("u%0d send accepted", i), (w < 500) ? 1 : 0, 1);
      @(posedge clk);
      #1;
      tvalid_v[i] = 1'b0;
   endtask

   task automatic wait_idle(input int i);
      int w = 0;
      while ((qsize(i) != 0 || in_frame[i] != 0) && w < 2000) begin
         @(negedge clk);
         w++;
      end
      chk($sformatf("u%0d drained", i), (w < 2000) ? 1 : 0, 1);
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ndone;
      for (int i = 0; i < NI; i++) tdata_a[i] = 8'h00;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("u%0d reset tx", i), tx_v[i], 1);
         chk($sformatf("u%0d reset busy", i), busy_v[i], 0);
         chk($sformatf("u%0d reset tready", i), rdy_v[i], 0);
         chk($sformatf("u%0d reset tx_done", i), done_v[i], 0);
      end
      rst_v = '0;
      @(negedge clk);
      for (int i = 0; i < NI; i++) chk($sformatf("u%0d tready after reset", i), rdy_v[i], 1);

      // 0xA7 has five ones: even parity 1, odd parity 0; 0xFF even parity 0.
      send(0, 8'hA7, 1'b1, 0, 1'b1);
      send(1, 8'hA7, 1'b0, 0, 1'b1);
      send(2, 8'h00, 1'b0, 0, 1'b1);
      send(3, 8'hFF, 1'b0, 0, 1'b1);
      wait_idle(0);

      // Back-to-back: 0x55 and 0x3C each have four ones, so even parity 0.
      send(0, 8'h55, 1'b0, 0, 1'b1);
      send(0, 8'h3C, 1'b0, 111, 1'b1);
      for (int i = 0; i < NI; i++) wait_idle(i);

      // Abort a frame with reset at its 40th cycle (data bit 2 of 0x81 is on the line).
      mon_en[0] = 1'b0;
      send(0, 8'h81, 1'b0, 0, 1'b0);
      repeat (39) @(posedge clk);
      #1;
      rst_v[0] = 1'b1;
      @(negedge clk);
      chk("u0 mid-frame tx", tx_v[0], 0);
      @(negedge clk);
      chk("u0 abort tx", tx_v[0], 1);
      chk("u0 abort busy", busy_v[0], 0);
      chk("u0 abort tready", rdy_v[0], 0);
      chk("u0 abort tx_done", done_v[0], 0);
      rst_v[0] = 1'b0;
      @(negedge clk);
      chk("u0 tready after abort", rdy_v[0], 1);
      ndone = 0;
      repeat (150) begin
         @(negedge clk);
         if (done_v[0] === 1'b1 || tx_v[0] !== 1'b1) ndone++;
      end
      chk("u0 quiet after abort", ndone, 0);
      mon_en[0] = 1'b1;

`ifdef UART_TX_FIFO_EN
      // Burst 0x01,0x03,0x07,0x0F,0x1F: even parity alternates 1,0,1,0,1.
      @(negedge clk);
      for (int j = 0; j < 5; j++) begin
         qpush(0, '{data: 8'((1 << (j + 1)) - 1), par: 1'((j + 1) % 2),
                    gap: (j == 0) ? 0 : 111});
         tdata_a[0]  = 8'((1 << (j + 1)) - 1);
         tvalid_v[0] = 1'b1;
         chk($sformatf("u0 burst tready %0d", j), rdy_v[0], 1);
         @(negedge clk);
      end
      chk("u0 burst full", rdy_v[0], 0);
      tvalid_v[0] = 1'b0;
`endif

      for (int i = 0; i < NI; i++) wait_idle(i);
      chk("u0 final busy", busy_v[0], 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_axis.md
Name: uart_tx_axis

Overview:
- UART transmitter; the transmit-side counterpart of the team's UART receiver.
- Accepts bytes on an AXI-Stream slave interface and serialises each as one frame: start, data LSB-first, optional parity, stop bits.
- Sits between the AXIS datapath and the board TX pin.
- Frame format matches the receiver's parameters, so a loopback tx->rx through both blocks is lossless.

Parameters:
- CLK_FREQ, 50_000_000: clock frequency in Hz.
- BAUD, 115200: line rate in bit/s. BAUD_DIV = CLK_FREQ/BAUD, integer division, must be >= 2.
- DATA_BITS, 8: data bits per frame, range 5..9.
- PARITY, "even": "none", "even" or "odd".
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: entry count, power of 2. Used only when UART_TX_FIFO_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  DATA_BITS  byte to send.
- s_axis_tvalid  in  1  tdata valid.
- s_axis_tready  out  1  block can accept a byte.
- tx  out  1  serial line, idle high.
- busy  out  1  frame in progress.
- tx_done  out  1  one-cycle pulse on the last cycle of the final stop bit.

Behaviour:
- Reset: one clock, synchronous, active-high (rst). While rst=1 at a clock edge, next state is:
  - state=IDLE, tx=1, busy=0, tx_done=0, s_axis_tready=0, all counters 0.
  - s_axis_tready rises the cycle after rst deasserts.
  - rst mid-frame aborts the frame immediately; tx returns high on that edge and no tx_done is issued.
- tx is a registered output with no combinational path from inputs.
- Handshake (no FIFO):
  - s_axis_tready = (state==IDLE) && !rst_q.
  - A transfer occurs on the edge where tvalid && tready. tdata is latched into shift_reg; parity is computed from the latched data.
  - tdata may change freely after the transfer.
- FSM states: IDLE, START, DATA, PARITY_S, STOP.
  - IDLE -> START on transfer. tx=0 from the next cycle.
  - START: tx=0 for BAUD_DIV cycles -> DATA.
  - DATA: tx=shift_reg[0]; shift right every BAUD_DIV cycles. After DATA_BITS bits -> PARITY_S, or -> STOP if PARITY=="none".
  - PARITY_S: tx = ^data for even, ~^data for odd, held for BAUD_DIV cycles -> STOP.
  - STOP: tx=1 for STOP_BITS*BAUD_DIV cycles. On the final cycle tx_done=1; next state IDLE.
- Every bit is exactly BAUD_DIV cycles. Frame length N = (1+DATA_BITS+P+STOP_BITS)*BAUD_DIV, where P = (PARITY!="none").
- Back-to-back: with tvalid held high, the next transfer occurs in the first IDLE cycle. Start-bit edges are then N+1 cycles apart (one idle cycle between frames, tx=1).
- baud_cnt width is $clog2(BAUD_DIV)+1. It wraps to 0 at BAUD_DIV-1. bit_cnt width is $clog2(DATA_BITS)+1.
- busy = (state!=IDLE).
- tvalid deasserting without a transfer has no effect. AXIS rules require tvalid to stay high until a transfer; the bench checks tdata stability.

Optional Feature:
- Macro UART_TX_FIFO_EN.
- Defined:
  - A FIFO_DEPTH-entry FIFO sits in front of the FSM. s_axis_tready = !fifo_full.
  - The FSM pops in IDLE when the FIFO is not empty.
  - A push and pop in the same cycle are both honoured. A push while full is impossible, because tready=0.
  - Back-to-back frames still include the one idle cycle.
  - busy = (state!=IDLE) || !fifo_empty.
  - rst clears the FIFO pointers; stored data is discarded.
- Undefined: single-byte behaviour exactly as in Behaviour, with no FIFO logic instantiated.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings: IDLE=0, START=1, DATA=2, PARITY_S=3, STOP=4 (3 bits).
  - a parity function parity_bit(data, mode), shared with the receiver.
  - the BAUD_DIV computation.
- Natural sub-module: uart_tx_fifo, a synchronous FIFO with full/empty flags. It is instantiated only under UART_TX_FIFO_EN.

Test Plan:
- Common bench setup: CLK_FREQ=1_000_000, BAUD=100_000 (BAUD_DIV=10), DATA_BITS=8, STOP_BITS=1.
- PARITY="even", send 0xA7:
  - tx bits 0,1,1,1,0,0,1,0,1, parity 1, stop 1, each held 10 cycles.
  - tx_done pulses at cycle 110 after the transfer; tready high again at cycle 111.
- PARITY="odd", 0xA7 -> parity bit 0. PARITY="none", 0x00 -> 100-cycle frame, no parity slot.
- tvalid held high with 0x55 then 0x3C -> start edges 111 cycles apart. A receiver in loopback yields 0x55, 0x3C with parity_error=0.
- rst asserted at cycle 40 of a frame:
  - tx=1 and busy=0 on the next edge; no tx_done.
  - tready high one cycle after rst drops.
- STOP_BITS=2, 0xFF even -> parity 0, frame 120 cycles, tx high for 20 cycles before tx_done.
- UART_TX_FIFO_EN, FIFO_DEPTH=4:
  - Burst of 5 bytes at 1/cycle -> tready=0 on the 6th cycle (4 in FIFO + 1 in flight).
  - All 5 bytes go out in order.
  - busy falls after the 5th tx_done.
